// File: rtl/mvau_inp_buf_ctrl_pkg.sv
// Shared types and helpers for the MVAU input-buffer controller.
package mvau_inp_buf_ctrl_pkg;

    typedef enum logic {
        IBUF_WRITE = 1'b0,
        IBUF_READ  = 1'b1
    } mvau_ibuf_state_t;

    // $clog2 clamped to a minimum of 1 so single-entry counters still get a bit.
    function automatic int clog2c(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mvau_inp_buf_ctrl_wrap_cnt.sv
// Modulo-MAX wrapping counter with a last-count flag; used for the sf and nf folds.
module mvau_wrap_cnt
    import mvau_inp_buf_ctrl_pkg::*;
#(
    parameter int MAX = 4,
    parameter int W   = clog2c(MAX)
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_en,
    output logic [W-1:0] o_cnt,
    output logic         o_last
);

    localparam logic [W-1:0] LAST = W'(MAX - 1);

    logic [W-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + 1'b1;
        end
    end

    assign o_cnt  = r_cnt;
    assign o_last = (r_cnt == LAST);

endmodule

// File: rtl/mvau_inp_buf_ctrl.sv
// MVAU input activation buffer sequencer: stores and forwards one vector, then replays it NF-1 times.
// Optional stall-cycle counter port enabled by defining MVAU_IBUF_PERF_EN.
module mvau_inp_buf_ctrl
    import mvau_inp_buf_ctrl_pkg::*;
#(
    parameter int TI      = 16,
    parameter int MatrixW = 20,
    parameter int MatrixH = 20,
    parameter int SIMD    = 2,
    parameter int PE      = 2,
    localparam int SF       = MatrixW / SIMD,
    localparam int NF       = MatrixH / PE,
    localparam int BUF_ADDR = clog2c(SF),
    localparam int NF_W     = clog2c(NF)
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_in_v,
    output logic                o_in_rdy,
    input  logic                i_out_rdy,
    output logic                o_out_v,
    output logic                o_buf_wr_en,
    output logic                o_buf_rd_en,
    output logic [BUF_ADDR-1:0] o_buf_addr,
    output logic                o_sf_last,
    output logic                o_nf_last
`ifdef MVAU_IBUF_PERF_EN
    ,
    output logic [31:0]         o_perf_stall_cnt
`endif
);

    if ((MatrixW % SIMD) != 0 || (MatrixH % PE) != 0 || TI < 1) begin : g_cfg_err
        $error("mvau_inp_buf_ctrl: MatrixW/SIMD and MatrixH/PE must divide evenly, TI >= 1");
    end

    mvau_ibuf_state_t  r_state;
    mvau_ibuf_state_t  w_state_nxt;
    logic              w_adv;
    logic [NF_W-1:0]   w_nf_cnt;
    logic              w_sf_last;
    logic              w_nf_last;

    assign w_adv = o_out_v & i_out_rdy;

    mvau_wrap_cnt #(.MAX(SF)) u_sf_cnt (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_en    (w_adv),
        .o_cnt   (o_buf_addr),
        .o_last  (w_sf_last)
    );

    mvau_wrap_cnt #(.MAX(NF)) u_nf_cnt (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_en    (w_adv & w_sf_last),
        .o_cnt   (w_nf_cnt),
        .o_last  (w_nf_last)
    );

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= IBUF_WRITE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        o_in_rdy    = 1'b0;
        o_out_v     = 1'b0;
        o_buf_wr_en = 1'b0;
        o_buf_rd_en = 1'b0;
        // Handshakes are held low while in reset so nothing is taken or emitted.
        if (i_rst_n) begin
            case (r_state)
                IBUF_WRITE: begin
                    o_in_rdy    = i_out_rdy;
                    o_out_v     = i_in_v;
                    o_buf_wr_en = i_in_v & i_out_rdy;
                end
                IBUF_READ: begin
                    o_out_v     = 1'b1;
                    o_buf_rd_en = 1'b1;
                end
                default: ;
            endcase
        end
        // The last word of the last pass returns to WRITE; any other vector end replays.
        if (o_out_v && i_out_rdy && w_sf_last) begin
            w_state_nxt = w_nf_last ? IBUF_WRITE : IBUF_READ;
        end
    end

    assign o_sf_last = w_sf_last;
    assign o_nf_last = w_nf_last;

`ifdef MVAU_IBUF_PERF_EN
    logic [31:0] r_perf_stall_cnt;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_perf_stall_cnt <= '0;
        end else if (!w_adv && (r_perf_stall_cnt != 32'hFFFF_FFFF)) begin
            r_perf_stall_cnt <= r_perf_stall_cnt + 32'd1;
        end
    end

    assign o_perf_stall_cnt = r_perf_stall_cnt;
`endif

endmodule

// File: tb/tb_mvau_inp_buf_ctrl.sv
// Bench for mvau_inp_buf_ctrl: DUT A (SF=4, NF=3) and DUT B (SF=3, NF=1) vs. a position-based model.
module tb_mvau_inp_buf_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0] in_v    = 2'b00;
    logic [1:0] out_rdy = 2'b00;
    logic [1:0] rst_n   = 2'b00;

    logic       a_in_rdy, a_out_v, a_wr, a_rd, a_sfl, a_nfl;
    logic [1:0] a_addr;
    logic       b_in_rdy, b_out_v, b_wr, b_rd, b_sfl, b_nfl;
    logic [1:0] b_addr;
`ifdef MVAU_IBUF_PERF_EN
    logic [31:0] a_perf, b_perf;
`endif

    mvau_inp_buf_ctrl #(.TI(16), .MatrixW(8), .MatrixH(6), .SIMD(2), .PE(2)) u_dut_a (
        .i_clk       (clk),
        .i_rst_n     (rst_n[0]),
        .i_in_v      (in_v[0]),
        .o_in_rdy    (a_in_rdy),
        .i_out_rdy   (out_rdy[0]),
        .o_out_v     (a_out_v),
        .o_buf_wr_en (a_wr),
        .o_buf_rd_en (a_rd),
        .o_buf_addr  (a_addr),
        .o_sf_last   (a_sfl),
        .o_nf_last   (a_nfl)
`ifdef MVAU_IBUF_PERF_EN
        ,
        .o_perf_stall_cnt (a_perf)
`endif
    );

    mvau_inp_buf_ctrl #(.TI(16), .MatrixW(6), .MatrixH(2), .SIMD(2), .PE(2)) u_dut_b (
        .i_clk       (clk),
        .i_rst_n     (rst_n[1]),
        .i_in_v      (in_v[1]),
        .o_in_rdy    (b_in_rdy),
        .i_out_rdy   (out_rdy[1]),
        .o_out_v     (b_out_v),
        .o_buf_wr_en (b_wr),
        .o_buf_rd_en (b_rd),
        .o_buf_addr  (b_addr),
        .o_sf_last   (b_sfl),
        .o_nf_last   (b_nfl)
`ifdef MVAU_IBUF_PERF_EN
        ,
        .o_perf_stall_cnt (b_perf)
`endif
    );

    int checks = 0;
    int errors = 0;

    // Model: position of the next word within the SF*NF sequence for one vector.
    int          SFm [2] = '{4, 3};
    int          NFm [2] = '{3, 1};
    int          pos [2] = '{0, 0};
    logic [31:0] perf[2] = '{32'd0, 32'd0};

    function automatic logic [7:0] got(int d);
        if (d == 0) return {a_in_rdy, a_out_v, a_wr, a_rd, a_addr, a_sfl, a_nfl};
        return {b_in_rdy, b_out_v, b_wr, b_rd, b_addr, b_sfl, b_nfl};
    endfunction

    // Expected {in_rdy, out_v, wr_en, rd_en, addr[1:0], sf_last, nf_last}.
    function automatic logic [7:0] expv(int d);
        int   pass = pos[d] / SFm[d];
        int   a    = pos[d] % SFm[d];
        logic ir, ov, w, r;
        if (pass == 0) begin
            ir = out_rdy[d]; ov = in_v[d]; w = in_v[d] & out_rdy[d]; r = 1'b0;
        end else begin
            ir = 1'b0; ov = 1'b1; w = 1'b0; r = 1'b1;
        end
        if (!rst_n[d]) begin
            ir = 1'b0; ov = 1'b0; w = 1'b0; r = 1'b0;
        end
        return {ir, ov, w, r, 2'(a), (a == SFm[d] - 1), (pass == NFm[d] - 1)};
    endfunction

    // Address and last flags are not defined while reset is held.
    function automatic logic [7:0] msk(int d);
        return rst_n[d] ? 8'hFF : 8'hF0;
    endfunction

    task automatic drv(input int d, input logic v, input logic r, input logic rs);
        @(negedge clk);
        in_v[d]    = v;
        out_rdy[d] = r;
        rst_n[d]   = rs;
        #1;
    endtask

    // Advance both models across the coming rising edge.
    task automatic upd();
        for (int d = 0; d < 2; d++) begin
            logic [7:0] e;
            e = expv(d);
            if (!rst_n[d]) begin
                pos[d]  = 0;
                perf[d] = 32'd0;
            end else if (e[6] && out_rdy[d]) begin
                pos[d] = (pos[d] + 1) % (SFm[d] * NFm[d]);
            end else if (perf[d] != 32'hFFFF_FFFF) begin
                perf[d] = perf[d] + 32'd1;
            end
        end
    endtask

    task automatic rst_cyc(input int d);
        drv(d, 1'b0, 1'b0, 1'b0);
        upd();
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            drv(0, 1'b1, 1'b1, 1'b0);
            checks++;
            if ((got(0) & 8'hE0) !== 8'h00) begin
                errors++;
                $display("FAIL reset_force cyc %0d got %b exp 000xxxxx", i, got(0));
            end
            upd();
        end
        drv(0, 1'b1, 1'b1, 1'b1);
        checks++;
        if (got(0) !== 8'hE0) begin
            errors++;
            $display("FAIL reset_state got %b exp %b", got(0), 8'hE0);
        end
        upd();
    endtask

    task automatic test_full_vector();
        int n_rd = 0, n_wr = 0;
        rst_cyc(0);
        for (int i = 0; i < 24; i++) begin
            drv(0, 1'b1, 1'b1, 1'b1);
            checks++;
            if (got(0) !== expv(0)) begin
                errors++;
                $display("FAIL full_vector cyc %0d got %b exp %b", i, got(0), expv(0));
            end
            n_rd += int'(a_rd);
            n_wr += int'(a_wr);
            upd();
        end
        checks++;
        if (n_rd != 16 || n_wr != 8) begin
            errors++;
            $display("FAIL full_vector_counts rd %0d wr %0d exp rd 16 wr 8", n_rd, n_wr);
        end
    endtask

    task automatic test_stall();
        rst_cyc(0);
        for (int i = 0; i < 14; i++) begin
            drv(0, 1'b1, !(i == 2 || i == 6), 1'b1);
            checks++;
            if (got(0) !== expv(0)) begin
                errors++;
                $display("FAIL stall cyc %0d got %b exp %b", i, got(0), expv(0));
            end
            upd();
        end
        drv(0, 1'b1, 1'b1, 1'b1);
        checks++;
        if ({a_rd, a_addr, a_wr} !== 4'b0001) begin
            errors++;
            $display("FAIL stall_wrap rd %b addr %0d wr %b exp rd 0 addr 0 wr 1", a_rd, a_addr, a_wr);
        end
        upd();
    endtask

    task automatic test_in_gaps();
        int n_wr = 0;
        rst_cyc(0);
        for (int i = 0; i < 8; i++) begin
            drv(0, (i % 2) == 0, 1'b1, 1'b1);
            checks++;
            if (got(0) !== expv(0)) begin
                errors++;
                $display("FAIL in_gaps cyc %0d got %b exp %b", i, got(0), expv(0));
            end
            n_wr += int'(a_wr);
            upd();
        end
        checks++;
        if (n_wr != 4) begin
            errors++;
            $display("FAIL in_gaps_wr got %0d exp 4", n_wr);
        end
    endtask

    task automatic test_nf1();
        int n_rd = 0, n_sfl = 0;
        rst_cyc(1);
        for (int i = 0; i < 12; i++) begin
            drv(1, 1'b1, 1'b1, 1'b1);
            checks++;
            if (got(1) !== expv(1) || b_nfl !== 1'b1) begin
                errors++;
                $display("FAIL nf1 cyc %0d got %b exp %b", i, got(1), expv(1));
            end
            n_rd  += int'(b_rd);
            n_sfl += int'(b_sfl);
            upd();
        end
        checks++;
        if (n_rd != 0 || n_sfl != 4) begin
            errors++;
            $display("FAIL nf1_counts rd %0d sf_last %0d exp rd 0 sf_last 4", n_rd, n_sfl);
        end
    endtask

    task automatic test_reset_mid();
        rst_cyc(0);
        for (int i = 0; i < 6; i++) begin
            drv(0, 1'b1, 1'b1, 1'b1);
            upd();
        end
        drv(0, 1'b1, 1'b0, 1'b1);
        checks++;
        if ({a_rd, a_addr, a_nfl} !== 4'b1100) begin
            errors++;
            $display("FAIL reset_mid_pre got rd %b addr %0d nfl %b exp rd 1 addr 2 nfl 0", a_rd, a_addr, a_nfl);
        end
        upd();
        drv(0, 1'b1, 1'b1, 1'b0);
        checks++;
        if ({a_in_rdy, a_out_v, a_wr, a_rd} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_mid_force got %b exp 0000", {a_in_rdy, a_out_v, a_wr, a_rd});
        end
        upd();
        drv(0, 1'b1, 1'b1, 1'b1);
        checks++;
        if (got(0) !== 8'hE0 || got(0) !== expv(0)) begin
            errors++;
            $display("FAIL reset_mid_post got %b exp %b", got(0), 8'hE0);
        end
        upd();
    endtask

    task automatic test_random();
        rst_cyc(0);
        rst_cyc(1);
        for (int i = 0; i < 400; i++) begin
            int d = (i < 200) ? 0 : 1;
            drv(d, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 49) != 0);
            checks++;
            if ((got(d) & msk(d)) !== (expv(d) & msk(d))) begin
                errors++;
                $display("FAIL random dut %0d cyc %0d got %b exp %b", d, i, got(d), expv(d));
            end
            upd();
        end
    endtask

    task automatic test_perf();
`ifdef MVAU_IBUF_PERF_EN
        rst_cyc(0);
        for (int i = 0; i < 17; i++) begin
            drv(0, !(i == 1 || i == 3), !(i == 2 || i == 6 || i == 9), 1'b1);
            if (i == 0) begin
                checks++;
                if (a_perf !== 32'd0) begin
                    errors++;
                    $display("FAIL perf_start got %0d exp 0", a_perf);
                end
            end
            upd();
        end
        drv(0, 1'b1, 1'b1, 1'b1);
        checks++;
        if (a_perf !== 32'd5 || a_perf !== perf[0]) begin
            errors++;
            $display("FAIL perf_count got %0d exp 5 (model %0d)", a_perf, perf[0]);
        end
        upd();
        rst_cyc(0);
        drv(0, 1'b1, 1'b1, 1'b1);
        checks++;
        if (a_perf !== 32'd0) begin
            errors++;
            $display("FAIL perf_clear got %0d exp 0", a_perf);
        end
        upd();
`endif
    endtask

    initial begin
        test_reset();
        test_full_vector();
        test_stall();
        test_in_gaps();
        test_nf1();
        test_reset_mid();
        test_perf();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
